// File: rtl/apb_ssi_fifo_regs_if.sv
// APB bus bundle between the bus master and the SSI register front-end.
interface apb_ssi_fifo_regs_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12
);
  logic                  p_sel;
  logic                  p_enable;
  logic                  p_write;
  logic [ADDR_WIDTH-1:0] p_addr;
  logic [DATA_WIDTH-1:0] p_wdata;
  logic [DATA_WIDTH-1:0] p_rdata;
  logic                  p_ready;
  logic                  p_slverr;

  modport master (
    output p_sel, p_enable, p_write, p_addr, p_wdata,
    input  p_rdata, p_ready, p_slverr
  );

  modport slave (
    input  p_sel, p_enable, p_write, p_addr, p_wdata,
    output p_rdata, p_ready, p_slverr
  );
endinterface

// File: rtl/apb_ssi_fifo_regs.sv
// APB register front-end for the SSI core: config registers, TX/RX FIFOs, masked interrupts.
// Optional error responses are built when APB_SSI_PSLVERR_EN is defined.
module apb_ssi_fifo_regs #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned FRAME_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                   p_clk,
  input  logic                   p_reset,
  apb_ssi_fifo_regs_if.slave     apb,
  output logic [15:0]            ssi_cr0,
  output logic [3:0]             ssi_cr1,
  output logic [7:0]             ssi_cpsdvsr,
  output logic [FRAME_WIDTH-1:0] tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  input  logic                   rx_valid,
  input  logic [FRAME_WIDTH-1:0] rx_data,
  input  logic                   spi_bsy,
  output logic                   ssi_intr
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned AW = ADDR_WIDTH - 2;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_CNT = CW'(FIFO_DEPTH / 2);
  localparam logic [AW-1:0] A_CR0 = AW'(0), A_CR1 = AW'(1), A_DR = AW'(2), A_SR = AW'(3),
                            A_CPSR = AW'(4), A_IMSC = AW'(5), A_RIS = AW'(6), A_MIS = AW'(7),
                            A_ICR = AW'(8);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_e;

  state_e state_q, state_d;
  logic [15:0] cr0_q;
  logic [3:0]  cr1_q;
  logic [7:0]  cpsr_q;
  logic [2:0]  imsc_q;
  logic        ror_q, intr_q;

  logic [FRAME_WIDTH-1:0] tx_mem [FIFO_DEPTH];
  logic [FRAME_WIDTH-1:0] rx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

  logic [AW-1:0] word_c;
  logic access_c, wr_c, rd_c;
  logic wr_cr0_c, wr_cr1_c, wr_dr_c, rd_dr_c, wr_cpsr_c, wr_imsc_c, wr_icr_c;
  logic sse_c, flush_c;
  logic tx_empty_c, tx_full_c, tx_push_c, tx_pop_c;
  logic rx_empty_c, rx_full_c, rx_push_c, rx_pop_c, ror_set_c;
  logic [2:0] ris_c, mis_c;
  logic [DATA_WIDTH-1:0] rdata_c;
  logic unused_ok;

  // state_d is the bus phase of the current cycle; state_q remembers the previous one
  always_ff @(posedge p_clk or posedge p_reset) begin
    if (p_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    if (apb.p_sel && !apb.p_enable) state_d = SETUP;
      SETUP:   if (apb.p_sel && apb.p_enable) state_d = ACCESS;
               else if (apb.p_sel)            state_d = SETUP;
      ACCESS:  if (apb.p_sel && !apb.p_enable) state_d = SETUP;
      default: state_d = IDLE;
    endcase
  end

  assign access_c  = (state_d == ACCESS);
  assign wr_c      = access_c & apb.p_write;
  assign rd_c      = access_c & ~apb.p_write;
  assign word_c    = apb.p_addr[ADDR_WIDTH-1:2];
  assign wr_cr0_c  = wr_c & (word_c == A_CR0);
  assign wr_cr1_c  = wr_c & (word_c == A_CR1);
  assign wr_dr_c   = wr_c & (word_c == A_DR);
  assign rd_dr_c   = rd_c & (word_c == A_DR);
  assign wr_cpsr_c = wr_c & (word_c == A_CPSR);
  assign wr_imsc_c = wr_c & (word_c == A_IMSC);
  assign wr_icr_c  = wr_c & (word_c == A_ICR);

  assign sse_c   = cr1_q[1];
  assign flush_c = wr_cr1_c & sse_c & ~apb.p_wdata[1];

  assign tx_empty_c = (tx_cnt_q == '0);
  assign tx_full_c  = (tx_cnt_q == FULL_CNT);
  assign tx_pop_c   = tx_valid & tx_ready;
  assign tx_push_c  = wr_dr_c & (~tx_full_c | tx_pop_c);
  assign rx_empty_c = (rx_cnt_q == '0);
  assign rx_full_c  = (rx_cnt_q == FULL_CNT);
  assign rx_pop_c   = rd_dr_c & ~rx_empty_c;
  assign rx_push_c  = rx_valid & (~rx_full_c | rx_pop_c);
  assign ror_set_c  = rx_valid & rx_full_c & ~rx_pop_c & ~flush_c;

  always_comb begin
    tx_wp_d = tx_wp_q; tx_rp_d = tx_rp_q; tx_cnt_d = tx_cnt_q;
    rx_wp_d = rx_wp_q; rx_rp_d = rx_rp_q; rx_cnt_d = rx_cnt_q;
    if (flush_c) begin
      tx_wp_d = '0; tx_rp_d = '0; tx_cnt_d = '0;
      rx_wp_d = '0; rx_rp_d = '0; rx_cnt_d = '0;
    end else begin
      if (tx_push_c) tx_wp_d = tx_wp_q + PW'(1);
      if (tx_pop_c)  tx_rp_d = tx_rp_q + PW'(1);
      if (tx_push_c && !tx_pop_c)      tx_cnt_d = tx_cnt_q + CW'(1);
      else if (!tx_push_c && tx_pop_c) tx_cnt_d = tx_cnt_q - CW'(1);
      if (rx_push_c) rx_wp_d = rx_wp_q + PW'(1);
      if (rx_pop_c)  rx_rp_d = rx_rp_q + PW'(1);
      if (rx_push_c && !rx_pop_c)      rx_cnt_d = rx_cnt_q + CW'(1);
      else if (!rx_push_c && rx_pop_c) rx_cnt_d = rx_cnt_q - CW'(1);
    end
  end

  // FIFO storage needs no reset: entries are only visible behind a non-zero count
  always_ff @(posedge p_clk) begin
    if (tx_push_c && !flush_c) tx_mem[tx_wp_q] <= apb.p_wdata[FRAME_WIDTH-1:0];
    if (rx_push_c && !flush_c) rx_mem[rx_wp_q] <= rx_data;
  end

  always_ff @(posedge p_clk or posedge p_reset) begin
    if (p_reset) begin
      cr0_q    <= '0;
      cr1_q    <= '0;
      cpsr_q   <= '0;
      imsc_q   <= '0;
      ror_q    <= 1'b0;
      intr_q   <= 1'b0;
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (wr_cr0_c)  cr0_q  <= apb.p_wdata[15:0];
      if (wr_cr1_c)  cr1_q  <= apb.p_wdata[3:0];
      if (wr_cpsr_c) cpsr_q <= {apb.p_wdata[7:1], 1'b0};
      if (wr_imsc_c) imsc_q <= apb.p_wdata[2:0];
      if (ror_set_c)                          ror_q <= 1'b1;
      else if (wr_icr_c && apb.p_wdata[0])    ror_q <= 1'b0;
      intr_q   <= |mis_c;
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      rx_cnt_q <= rx_cnt_d;
    end
  end

  assign ris_c = {(tx_cnt_q <= HALF_CNT) & sse_c, (rx_cnt_q >= HALF_CNT), ror_q};
  assign mis_c = ris_c & imsc_q;

  always_comb begin
    rdata_c = '0;
    if (rd_c) begin
      case (word_c)
        A_CR0:   rdata_c = DATA_WIDTH'(cr0_q);
        A_CR1:   rdata_c = DATA_WIDTH'(cr1_q);
        A_DR:    if (!rx_empty_c) rdata_c = DATA_WIDTH'(rx_mem[rx_rp_q]);
        A_SR:    rdata_c = DATA_WIDTH'({spi_bsy, rx_full_c, ~rx_empty_c, ~tx_full_c, tx_empty_c});
        A_CPSR:  rdata_c = DATA_WIDTH'(cpsr_q);
        A_IMSC:  rdata_c = DATA_WIDTH'(imsc_q);
        A_RIS:   rdata_c = DATA_WIDTH'(ris_c);
        A_MIS:   rdata_c = DATA_WIDTH'(mis_c);
        default: rdata_c = '0;
      endcase
    end
  end

  assign apb.p_rdata = rdata_c;
  assign apb.p_ready = access_c;

`ifdef APB_SSI_PSLVERR_EN
  logic bad_wr_addr_c;
  assign bad_wr_addr_c = !(word_c inside {A_CR0, A_CR1, A_DR, A_CPSR, A_IMSC, A_ICR});
  // Dropped writes and empty reads still follow the normal side-effect rules
  assign apb.p_slverr = (wr_c & bad_wr_addr_c) | (wr_dr_c & tx_full_c & ~tx_pop_c) |
                        (rd_dr_c & rx_empty_c);
`else
  assign apb.p_slverr = 1'b0;
`endif

  assign ssi_cr0     = cr0_q;
  assign ssi_cr1     = cr1_q;
  assign ssi_cpsdvsr = cpsr_q;
  assign tx_data     = tx_mem[tx_rp_q];
  assign tx_valid    = ~tx_empty_c & sse_c;
  assign ssi_intr    = intr_q;
  assign unused_ok   = ^{apb.p_wdata, apb.p_addr[1:0]};
endmodule

// File: tb/tb_apb_ssi_fifo_regs.sv
// Self-checking bench for apb_ssi_fifo_regs against a queue-based register/FIFO model.
module tb_apb_ssi_fifo_regs;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 12;
  localparam int unsigned FW = 16;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  logic tx_ready, rx_valid, spi_bsy;
  logic [FW-1:0] rx_data, tx_data;
  logic [15:0] ssi_cr0;
  logic [3:0]  ssi_cr1;
  logic [7:0]  ssi_cpsdvsr;
  logic tx_valid, ssi_intr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  apb_ssi_fifo_regs_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  apb_ssi_fifo_regs #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_WIDTH(FW), .FIFO_DEPTH(DEPTH)) dut (
    .p_clk(clk), .p_reset(rst), .apb(bus),
    .ssi_cr0(ssi_cr0), .ssi_cr1(ssi_cr1), .ssi_cpsdvsr(ssi_cpsdvsr),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .spi_bsy(spi_bsy), .ssi_intr(ssi_intr)
  );

  // Reference model state
  logic [15:0] m_cr0;
  logic [3:0]  m_cr1;
  logic [7:0]  m_cpsr;
  logic [2:0]  m_imsc;
  logic        m_ror;
  logic [15:0] txq[$];
  logic [15:0] rxq[$];

  task automatic model_reset();
    m_cr0 = '0; m_cr1 = '0; m_cpsr = '0; m_imsc = '0; m_ror = 1'b0;
    txq.delete(); rxq.delete();
  endtask

  function automatic logic [31:0] m_sr();
    return {27'd0, spi_bsy, rxq.size() == DEPTH, rxq.size() != 0, txq.size() != DEPTH, txq.size() == 0};
  endfunction

  function automatic logic [31:0] m_ris();
    return {29'd0, (txq.size() <= DEPTH / 2) && m_cr1[1], rxq.size() >= DEPTH / 2, m_ror};
  endfunction

  function automatic logic m_intr();
    logic [31:0] mis;
    mis = m_ris() & {29'd0, m_imsc};
    return |mis;
  endfunction

  // One APB transfer as seen by the model; rxp models a core frame arriving in the same cycle
  task automatic model_access(input bit wr, input logic [11:0] addr, input logic [31:0] wd,
                              input bit rxp, input logic [15:0] rxd,
                              output logic [31:0] rd, output logic err);
    bit flushed = 0;
    rd = '0; err = 1'b0;
    if (!wr) begin
      case (int'(addr[11:2]))
        0: rd = {16'd0, m_cr0};
        1: rd = {28'd0, m_cr1};
        2: if (rxq.size() != 0) rd = {16'd0, rxq.pop_front()}; else err = 1'b1;
        3: rd = m_sr();
        4: rd = {24'd0, m_cpsr};
        5: rd = {29'd0, m_imsc};
        6: rd = m_ris();
        7: rd = m_ris() & {29'd0, m_imsc};
        default: rd = '0;
      endcase
    end else begin
      case (int'(addr[11:2]))
        0: m_cr0 = wd[15:0];
        1: begin
             if (m_cr1[1] && !wd[1]) begin txq.delete(); rxq.delete(); flushed = 1; end
             m_cr1 = wd[3:0];
           end
        2: if (txq.size() < DEPTH) txq.push_back(wd[15:0]); else err = 1'b1;
        4: m_cpsr = wd[7:0] & 8'hFE;
        5: m_imsc = wd[2:0];
        8: if (wd[0]) m_ror = 1'b0;
        default: err = 1'b1;
      endcase
    end
    if (rxp && !flushed) begin
      if (rxq.size() < DEPTH) rxq.push_back(rxd); else m_ror = 1'b1;
    end
`ifndef APB_SSI_PSLVERR_EN
    err = 1'b0;
`endif
  endtask

  task automatic apb_xfer(input bit wr, input logic [11:0] addr, input logic [31:0] wd,
                          input bit rxp, input logic [15:0] rxd,
                          output logic [31:0] ard, output logic aerr, output logic ardy);
    @(posedge clk); #1;
    bus.p_sel = 1'b1; bus.p_enable = 1'b0; bus.p_write = wr; bus.p_addr = addr; bus.p_wdata = wd;
    @(posedge clk); #1;
    bus.p_enable = 1'b1; rx_valid = rxp; rx_data = rxd;
    @(negedge clk);
    ard = bus.p_rdata; aerr = bus.p_slverr; ardy = bus.p_ready;
    @(posedge clk); #1;
    bus.p_sel = 1'b0; bus.p_enable = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic bus_op(input bit wr, input logic [11:0] addr, input logic [31:0] wd,
                        input bit rxp, input logic [15:0] rxd,
                        output logic [31:0] ard, output logic aerr, output logic ardy,
                        output logic [31:0] erd, output logic eerr);
    model_access(wr, addr, wd, rxp, rxd, erd, eerr);
    apb_xfer(wr, addr, wd, rxp, rxd, ard, aerr, ardy);
  endtask

  task automatic rx_pulse(input logic [15:0] d);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = d;
    if (rxq.size() < DEPTH) rxq.push_back(d); else m_ror = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] ard, erd; logic aerr, ardy, eerr;
    #3;
    checks++;
    if ({bus.p_ready, bus.p_slverr, bus.p_rdata, tx_valid, ssi_intr, ssi_cr0, ssi_cr1, ssi_cpsdvsr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b err=%b rd=%h txv=%b intr=%b cr0=%h cr1=%h cps=%h, want all 0",
               bus.p_ready, bus.p_slverr, bus.p_rdata, tx_valid, ssi_intr, ssi_cr0, ssi_cr1, ssi_cpsdvsr);
    end
    @(negedge clk); rst = 1'b0; model_reset();
    bus_op(1, 12'h000, 32'h1234, 0, 0, ard, aerr, ardy, erd, eerr);
    // Assert reset in the middle of an ACCESS cycle
    @(posedge clk); #1;
    bus.p_sel = 1'b1; bus.p_enable = 1'b0; bus.p_write = 1'b1; bus.p_addr = 12'h000; bus.p_wdata = 32'h5555;
    @(posedge clk); #1;
    bus.p_enable = 1'b1;
    #1; checks++;
    if (bus.p_ready !== 1'b1) begin errors++; $display("FAIL access_ready: got %b want 1", bus.p_ready); end
    #1; rst = 1'b1; #1; checks++;
    if (bus.p_ready !== 1'b0 || ssi_cr0 !== 16'h0) begin
      errors++; $display("FAIL reset_mid_xfer: got rdy=%b cr0=%h want rdy=0 cr0=0000", bus.p_ready, ssi_cr0);
    end
    @(negedge clk); bus.p_sel = 1'b0; bus.p_enable = 1'b0;
    @(negedge clk); rst = 1'b0; model_reset();
    bus_op(0, 12'h00C, 0, 0, 0, ard, aerr, ardy, erd, eerr);
    checks++;
    if (ard !== 32'h3 || ard !== erd || ardy !== 1'b1) begin
      errors++; $display("FAIL reset_sr: got %h rdy=%b want 00000003", ard, ardy);
    end
    bus_op(0, 12'h000, 0, 0, 0, ard, aerr, ardy, erd, eerr);
    checks++;
    if (ard !== 32'h0) begin errors++; $display("FAIL reset_cr0: got %h want 0", ard); end
    bus_op(1, 12'h000, 32'hABCD, 0, 0, ard, aerr, ardy, erd, eerr);
    bus_op(0, 12'h000, 0, 0, 0, ard, aerr, ardy, erd, eerr);
    checks++;
    if (ard !== 32'h0000ABCD || ard !== erd) begin
      errors++; $display("FAIL cr0_readback: got %h want 0000abcd", ard);
    end
  endtask

  task automatic test_regs();
    logic [31:0] ard, erd; logic aerr, ardy, eerr;
    logic [11:0] ta [9] = '{12'h010, 12'h010, 12'h00C, 12'h018, 12'h00C, 12'h018, 12'h024, 12'h040, 12'h014};
    bit          tw [9] = '{1, 0, 1, 1, 0, 0, 0, 1, 0};
    for (int i = 0; i < 9; i++) begin
      bus_op(tw[i], ta[i], (i == 0) ? 32'hFF : 32'h0, 0, 0, ard, aerr, ardy, erd, eerr);
      checks++;
      if (ard !== erd || aerr !== eerr || ardy !== 1'b1) begin
        errors++;
        $display("FAIL regs_op%0d: got rd=%h err=%b rdy=%b want rd=%h err=%b rdy=1", i, ard, aerr, ardy, erd, eerr);
      end
    end
    checks++;
    if (ssi_cpsdvsr !== 8'hFE) begin errors++; $display("FAIL cpsdvsr: got %h want fe", ssi_cpsdvsr); end
    spi_bsy = 1'b1;
    bus_op(0, 12'h00C, 0, 0, 0, ard, aerr, ardy, erd, eerr);
    checks++;
    if (ard !== erd || ard !== 32'h13) begin errors++; $display("FAIL sr_bsy: got %h want 00000013", ard); end
    spi_bsy = 1'b0;
  endtask

  task automatic test_tx_fill_drain();
    logic [31:0] ard, erd; logic aerr, ardy, eerr;
    bus_op(1, 12'h004, 32'h2, 0, 0, ard, aerr, ardy, erd, eerr);
    for (int i = 1; i <= 9; i++) begin
      bus_op(1, 12'h008, 32'(i), 0, 0, ard, aerr, ardy, erd, eerr);
      checks++;
      if (aerr !== eerr || ardy !== 1'b1) begin
        errors++; $display("FAIL tx_push%0d: got err=%b rdy=%b want err=%b rdy=1", i, aerr, ardy, eerr);
      end
      if (i == 8) begin
        bus_op(0, 12'h00C, 0, 0, 0, ard, aerr, ardy, erd, eerr);
        checks++;
        if (ard !== erd || ard[1] !== 1'b0) begin errors++; $display("FAIL tx_full_sr: got %h want %h", ard, erd); end
      end
    end
    @(posedge clk); #1; tx_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== txq[0]) begin
        errors++; $display("FAIL tx_drain%0d: got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, txq[0]);
      end
      void'(txq.pop_front());
      @(posedge clk);
    end
    #1; tx_ready = 1'b0;
    @(negedge clk); checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_drained: got v=%b want 0", tx_valid); end
  endtask

  task automatic test_rx_overrun();
    logic [31:0] ard, erd; logic aerr, ardy, eerr;
    bus_op(1, 12'h004, 32'h0, 0, 0, ard, aerr, ardy, erd, eerr);
    for (int i = 0; i <= DEPTH; i++) rx_pulse(16'h100 + 16'(i));
    bus_op(0, 12'h018, 0, 0, 0, ard, aerr, ardy, erd, eerr);
    checks++;
    if (ard !== erd || ard !== 32'h3) begin errors++; $display("FAIL ris_overrun: got %h want 00000003", ard); end
    bus_op(1, 12'h014, 32'h1, 0, 0, ard, aerr, ardy, erd, eerr);
    checks++;
    if (ssi_intr !== 1'b0) begin errors++; $display("FAIL intr_lag: got %b want 0", ssi_intr); end
    @(posedge clk); #1; checks++;
    if (ssi_intr !== 1'b1) begin errors++; $display("FAIL intr_set: got %b want 1", ssi_intr); end
    bus_op(1, 12'h020, 32'h1, 0, 0, ard, aerr, ardy, erd, eerr);
    bus_op(0, 12'h018, 0, 0, 0, ard, aerr, ardy, erd, eerr);
    checks++;
    if (ard !== erd || ard !== 32'h2) begin errors++; $display("FAIL ris_cleared: got %h want 00000002", ard); end
    checks++;
    if (ssi_intr !== 1'b0) begin errors++; $display("FAIL intr_clear: got %b want 0", ssi_intr); end
  endtask

  task automatic test_rx_simul();
    logic [31:0] ard, erd; logic aerr, ardy, eerr;
    bus_op(0, 12'h008, 0, 1, 16'hBEEF, ard, aerr, ardy, erd, eerr);
    checks++;
    if (ard !== erd || ard !== 32'h100) begin errors++; $display("FAIL simul_read: got %h want 00000100", ard); end
    bus_op(0, 12'h018, 0, 0, 0, ard, aerr, ardy, erd, eerr);
    checks++;
    if (ard !== erd || ard !== 32'h2) begin errors++; $display("FAIL simul_no_ovr: got %h want 00000002", ard); end
    for (int i = 0; i <= DEPTH; i++) begin
      bus_op(0, (i == 0) ? 12'h00C : 12'h008, 0, 0, 0, ard, aerr, ardy, erd, eerr);
      checks++;
      if (ard !== erd || aerr !== eerr) begin
        errors++; $display("FAIL rx_pop%0d: got rd=%h err=%b want rd=%h err=%b", i, ard, aerr, erd, eerr);
      end
    end
    bus_op(0, 12'h008, 0, 0, 0, ard, aerr, ardy, erd, eerr);
    checks++;
    if (ard !== 32'h0 || aerr !== eerr) begin
      errors++; $display("FAIL rx_empty_read: got rd=%h err=%b want rd=0 err=%b", ard, aerr, eerr);
    end
  endtask

  task automatic test_flush();
    logic [31:0] ard, erd; logic aerr, ardy, eerr;
    bus_op(1, 12'h004, 32'h2, 0, 0, ard, aerr, ardy, erd, eerr);
    for (int i = 0; i < 3; i++) bus_op(1, 12'h008, 32'hA0 + 32'(i), 0, 0, ard, aerr, ardy, erd, eerr);
    rx_pulse(16'h55); rx_pulse(16'h66);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 16'hA0) begin
      errors++; $display("FAIL pre_flush: got v=%b d=%h want v=1 d=00a0", tx_valid, tx_data);
    end
    bus_op(1, 12'h004, 32'h0, 0, 0, ard, aerr, ardy, erd, eerr);
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL flush_txv: got %b want 0", tx_valid); end
    bus_op(0, 12'h00C, 0, 0, 0, ard, aerr, ardy, erd, eerr);
    checks++;
    if (ard !== erd || ard !== 32'h3) begin errors++; $display("FAIL flush_sr: got %h want 00000003", ard); end
  endtask

  task automatic test_random();
    logic [31:0] ard, erd; logic aerr, ardy, eerr;
    logic [11:0] addrs [12] = '{12'h000, 12'h004, 12'h008, 12'h008, 12'h008, 12'h00C,
                               12'h010, 12'h014, 12'h018, 12'h01C, 12'h020, 12'h024};
    logic [11:0] a; bit wr;
    bus_op(1, 12'h004, 32'h2, 0, 0, ard, aerr, ardy, erd, eerr);
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) < 3) begin
        rx_pulse(16'($urandom));
      end else begin
        a  = addrs[$urandom_range(0, 11)];
        wr = 1'($urandom);
        if (wr && a == 12'h004) a = 12'h000;
        bus_op(wr, a, $urandom, 0, 0, ard, aerr, ardy, erd, eerr);
        checks++;
        if (ard !== erd || aerr !== eerr || ardy !== 1'b1) begin
          errors++;
          $display("FAIL rnd%0d a=%h w=%b: got rd=%h err=%b rdy=%b want rd=%h err=%b rdy=1",
                   n, a, wr, ard, aerr, ardy, erd, eerr);
        end
      end
      @(posedge clk); #1;
      checks++;
      if (ssi_intr !== m_intr() || tx_valid !== (txq.size() != 0)) begin
        errors++;
        $display("FAIL rnd%0d_status: got intr=%b txv=%b want intr=%b txv=%b",
                 n, ssi_intr, tx_valid, m_intr(), txq.size() != 0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.p_sel = 1'b0; bus.p_enable = 1'b0; bus.p_write = 1'b0; bus.p_addr = '0; bus.p_wdata = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0; spi_bsy = 1'b0;
    model_reset();
    test_reset();
    test_regs();
    test_tx_fill_drain();
    test_rx_overrun();
    test_rx_simul();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/apb_ssi_fifo_regs.md
Name: apb_ssi_fifo_regs

Overview:
Next-generation APB register front-end for the SSI controller, parametrised in frame width and FIFO depth. Adds TX and RX FIFOs behind the DR address, live status, and a masked interrupt set (IMSC/RIS/MIS/ICR). It sits between the APB bus and the SSI shift core and drives static configuration fields plus FIFO handshakes toward the core.

Parameters:
DATA_WIDTH, 32, APB data width (>= FRAME_WIDTH, >= 16)
ADDR_WIDTH, 12, APB address width
FRAME_WIDTH, 16, SSI frame width held per FIFO entry (4..16)
FIFO_DEPTH, 8, entries per TX and RX FIFO (power of 2, >= 2)

Ports:
p_clk  in  1  APB and core clock
p_reset  in  1  reset, asynchronous, active-high
p_sel  in  1  APB select
p_enable  in  1  APB enable
p_write  in  1  1 = write
p_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored
p_wdata  in  DATA_WIDTH  write data
p_rdata  out  DATA_WIDTH  read data
p_ready  out  1  transfer complete
p_slverr  out  1  error response (tied 0 unless macro enabled)
ssi_cr0  out  16  CR0 fields: scr[15:8], sph[7], spo[6], frf[5:4], dss[3:0]
ssi_cr1  out  4  CR1 fields: sod[3], ms[2], sse[1], lbm[0]
ssi_cpsdvsr  out  8  clock prescale divisor, bit0 always 0
tx_data  out  FRAME_WIDTH  head of TX FIFO
tx_valid  out  1  TX FIFO non-empty and sse=1
tx_ready  in  1  core consumes tx_data when tx_valid=1
rx_valid  in  1  core pushes rx_data
rx_data  in  FRAME_WIDTH  received frame
spi_bsy  in  1  core busy
ssi_intr  out  1  OR of MIS bits

Behaviour:
- One clock domain: p_clk. Reset is asynchronous and active-high on p_reset; all state clears immediately on assertion.
- Reset values: all config registers, IMSC, and RIS are 0. Both FIFOs are empty. p_rdata=0, p_slverr=0, tx_valid=0, ssi_intr=0. SR reads 0x03.
- APB FSM has three states: IDLE, SETUP (p_sel & !p_enable), and ACCESS (p_sel & p_enable).
  - p_ready=1 only in ACCESS, so every transfer is two cycles with zero wait states.
  - ACCESS returns to SETUP if p_sel remains high with p_enable low; otherwise it returns to IDLE.
- Side effects (register writes, FIFO push/pop, ICR clear) occur only on the ACCESS cycle with p_ready=1. Each transfer produces exactly one effect.
- p_rdata is combinational from the address during ACCESS and 0 otherwise. Unmapped addresses read 0.
- Register map:
  - 0x00 CR0 (RW, [15:0])
  - 0x04 CR1 (RW, [3:0])
  - 0x08 DR: write pushes p_wdata[FRAME_WIDTH-1:0] to TX; read pops RX head, zero-extended
  - 0x0C SR (RO): {bsy, rff, rne, tnf, tfe} in [4:0], live
  - 0x10 CPSR (RW, [7:0], bit0 forced 0)
  - 0x14 IMSC (RW, [2:0])
  - 0x18 RIS (RO)
  - 0x1C MIS (RO) = RIS & IMSC
  - 0x20 ICR (WO): writing 1 clears the RORIS bit
- Interrupt bits:
  - bit0 RORIS: RX overrun, sticky until cleared via ICR.
  - bit1 RXIS: RX count >= FIFO_DEPTH/2, level-sensitive.
  - bit2 TXIS: TX count <= FIFO_DEPTH/2 and sse=1, level-sensitive.
- FIFOs use binary pointers plus a count of width clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop: both occur and count is unchanged. This is legal when full (TX: APB write + tx_ready) and when empty-with-push for RX (no pop, since empty reads don't pop).
  - DR write with TX full: data is dropped and count is unchanged.
  - DR read with RX empty: returns 0, no pointer move.
  - rx_valid with RX full: frame is dropped and RORIS is set the next cycle. A simultaneous APB pop makes room, so there is no overrun.
- tx_valid = !tx_empty & sse. The TX pop happens on tx_valid & tx_ready. tx_data is the registered FIFO head with no bubble between back-to-back pops.
- CR1 write that changes sse 1->0 flushes both FIFOs on that same clock edge. Pushes in that same cycle are discarded. RIS.RORIS is unaffected.
- ssi_intr is registered: asserts one cycle after a MIS bit becomes 1.

Optional Feature:
Macro APB_SSI_PSLVERR_EN.
- Defined: p_slverr=1 in the ACCESS cycle for:
  - a write to a RO or unmapped address;
  - a DR write with TX full;
  - a DR read with RX empty.
  The underlying side-effect rules are unchanged.
- Undefined: p_slverr is tied to 0 and the error-detect logic is not built.

Test Plan:
- Reset pulse mid-transfer (p_reset=1 during ACCESS) -> p_ready=0 immediately; SR=0x03, CR0=0, no FIFO change; after release a CR0 write of 0xABCD reads back 0x0000ABCD.
- With sse=1 and tx_ready=0, write DR 9 times (FIFO_DEPTH=8) -> SR.tnf=0 after the 8th; the 9th is dropped (p_slverr=1 with macro); tx_ready=1 drains exactly 8 frames in order 1..8 on consecutive cycles.
- Push 8 rx frames then a 9th -> RIS=0x3 (RORIS|RXIS); IMSC=0x1 gives ssi_intr=1 one cycle later; ICR write 0x1 -> RIS.RORIS=0, ssi_intr=0.
- RX full plus simultaneous APB DR read and rx_valid -> no overrun; count stays 8; the read returns the oldest frame.
- CPSR write 0xFF -> reads 0xFE, ssi_cpsdvsr=0xFE; writing 0 to SR/RIS leaves their values unchanged.
- Load 3 TX frames with sse=1, tx_ready=0, then write CR1=0x0 -> next cycle tx_valid=0, SR.tfe=1, RX count=0.
